// File: rtl/scr1_ahb_sram_pkg.sv
// scr1_ahb_sram_pkg: types shared by the AHB-to-SRAM bridge and its write
// buffer: data-phase FSM encoding, write-buffer entry and the byte-lane
// decoder. Also re-exports the AHB encodings from scr1_ahb.svh.
package scr1_ahb_sram_pkg;

  `include "scr1_ahb.svh"

  // Type of the data phase currently on the bus.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Widest possible word address (32-bit byte space); the bridge uses the
  // low SRAM_AW bits.
  localparam int unsigned WB_AW = 30;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [3:0]       be;
    logic [31:0]      data;
  } wbuf_entry_t;

  // Byte lanes touched by a transfer; sizes above word count as word.
  function automatic logic [3:0] lane_be(input logic [2:0] hsize,
                                         input logic [1:0] addr_lo);
    case (hsize)
      SCR1_HSIZE_BYTE: lane_be = 4'b0001 << addr_lo;
      SCR1_HSIZE_HALF: lane_be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:         lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/scr1_ahb.svh
// Shared AHB-Lite encodings: transfer type, transfer size and response.
// Included inside scr1_ahb_sram_pkg, so importing that package brings these
// constants into scope.
`ifndef SCR1_AHB_SVH
`define SCR1_AHB_SVH

localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

localparam logic [2:0] SCR1_HSIZE_BYTE = 3'b000;
localparam logic [2:0] SCR1_HSIZE_HALF = 3'b001;
localparam logic [2:0] SCR1_HSIZE_WORD = 3'b010;

localparam logic SCR1_HRESP_OKAY  = 1'b0;
localparam logic SCR1_HRESP_ERROR = 1'b1;

`endif

// File: rtl/scr1_ahb_sram_wbuf.sv
// scr1_ahb_sram_wbuf: one-entry posted-write buffer plus the read-forwarding
// compare.
//   push/push_entry : load a completed write (wins over a same-cycle drain)
//   drain           : the entry is being written to SRAM this cycle
//   wb_valid/wb_*   : current entry, SRAM-side view
//   lookup_addr     : word address of a read address phase
//   fly_*           : write whose data phase completes this cycle
//   fwd_mask/data   : per-byte bytes newer than SRAM for lookup_addr
module scr1_ahb_sram_wbuf
  import scr1_ahb_sram_pkg::*;
#(
  parameter int unsigned SRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  wbuf_entry_t        push_entry,
  input  logic               drain,
  output logic               wb_valid,
  output logic [SRAM_AW-1:0] wb_addr,
  output logic [3:0]         wb_be,
  output logic [31:0]        wb_data,
  input  logic [SRAM_AW-1:0] lookup_addr,
  input  logic               fly_vld,
  input  logic [SRAM_AW-1:0] fly_addr,
  input  logic [3:0]         fly_be,
  input  logic [31:0]        fly_data,
  output logic [3:0]         fwd_mask,
  output logic [31:0]        fwd_data
);

  logic        valid_q, valid_d;
  wbuf_entry_t entry_q, entry_d;
  logic        buf_hit, fly_hit;
  logic        unused_addr_hi;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (push) begin
      valid_d = 1'b1;
      entry_d = push_entry;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign wb_valid       = valid_q;
  assign wb_addr        = entry_q.addr[SRAM_AW-1:0];
  assign wb_be          = entry_q.be;
  assign wb_data        = entry_q.data;
  assign unused_addr_hi = ^entry_q.addr[WB_AW-1:SRAM_AW];

  assign buf_hit = valid_q & (entry_q.addr[SRAM_AW-1:0] == lookup_addr);
  assign fly_hit = fly_vld & (fly_addr == lookup_addr);

  // The in-flight write is younger than the buffered one, so its lanes win.
  always_comb begin
    fwd_data = '0;
    fwd_mask = (fly_hit ? fly_be : 4'b0000) | (buf_hit ? entry_q.be : 4'b0000);
    for (int i = 0; i < 4; i++) begin
      if (fly_hit && fly_be[i]) begin
        fwd_data[8*i +: 8] = fly_data[8*i +: 8];
      end else if (buf_hit && entry_q.be[i]) begin
        fwd_data[8*i +: 8] = entry_q.data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/scr1_ahb_sram_bridge.sv
// scr1_ahb_sram_bridge: AHB-Lite slave in front of a single-port synchronous
// SRAM (read data one cycle after the access). Reads are zero-wait; writes
// are posted into a one-entry buffer and drained whenever the SRAM port is
// not taken by a read. Reads see posted/in-flight writes through per-byte
// forwarding.
//   AHB : hsel, htrans, hsize, haddr, hwrite, hwdata, hready -> hreadyout,
//         hresp, hrdata
//   SRAM: sram_cs, sram_we, sram_be, sram_addr, sram_wdata <- sram_rdata
// Build option SCR1_AHB_SRAM_ERR_EN: misaligned, oversize and out-of-range
// transfers get a two-cycle ERROR response. Without it hresp is tied OKAY,
// high address bits alias and sizes above word act as word.
module scr1_ahb_sram_bridge
  import scr1_ahb_sram_pkg::*;
#(
  parameter int unsigned SRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsel,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [31:0]        haddr,
  input  logic               hwrite,
  input  logic [31:0]        hwdata,
  input  logic               hready,
  output logic               hreadyout,
  output logic               hresp,
  output logic [31:0]        hrdata,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  state_e             state_q, state_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [3:0]         fwd_mask_q, fwd_mask_d;
  logic [31:0]        fwd_data_q, fwd_data_d;

  logic               trans_act, wr_dp, stall, hold, acc, err;
  logic               rd_acc, wb_push, wb_drain;
  logic [SRAM_AW-1:0] haddr_word;
  logic [3:0]         hlanes;
  wbuf_entry_t        wb_push_entry;
  logic               wb_valid;
  logic [SRAM_AW-1:0] wb_addr;
  logic [3:0]         wb_be, wb_fwd_mask;
  logic [31:0]        wb_data, wb_fwd_data;

  assign trans_act  = (htrans == SCR1_HTRANS_NONSEQ) || (htrans == SCR1_HTRANS_SEQ);
  assign haddr_word = haddr[SRAM_AW+1:2];
  assign hlanes     = lane_be(hsize, haddr[1:0]);
  assign wr_dp      = (state_q == ST_WR);

  // A write data phase cannot post while a read holds the SRAM port and the
  // buffer is still full: stretch the write one cycle so the buffer drains.
  // Built from the request only, never from hready.
  assign stall     = wr_dp & wb_valid & hsel & trans_act & ~hwrite;
  assign hold      = stall | (state_q == ST_ERR1);
  assign hreadyout = ~hold;

  // rst_n gates acceptance so no SRAM access can leak out while in reset.
  assign acc    = rst_n & hsel & hready & trans_act & ~hold;
  assign rd_acc = acc & ~err & ~hwrite;

  assign wb_push  = wr_dp & ~stall;
  assign wb_drain = wb_valid & ~rd_acc;

`ifdef SCR1_AHB_SRAM_ERR_EN
  always_comb begin
    case (hsize)
      SCR1_HSIZE_BYTE: err = 1'b0;
      SCR1_HSIZE_HALF: err = haddr[0];
      SCR1_HSIZE_WORD: err = |haddr[1:0];
      default:         err = 1'b1;
    endcase
    if (|haddr[31:SRAM_AW+2]) err = 1'b1;
  end
  assign hresp = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ?
                 SCR1_HRESP_ERROR : SCR1_HRESP_OKAY;
`else
  logic unused_addr_hi;
  assign err            = 1'b0;
  assign hresp          = SCR1_HRESP_OKAY;
  assign unused_addr_hi = ^haddr[31:SRAM_AW+2];
`endif

  always_comb begin
    wb_push_entry                   = '0;
    wb_push_entry.addr[SRAM_AW-1:0] = addr_q;
    wb_push_entry.be                = be_q;
    wb_push_entry.data              = hwdata;
  end

  scr1_ahb_sram_wbuf #(.SRAM_AW(SRAM_AW)) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (wb_push),
    .push_entry  (wb_push_entry),
    .drain       (wb_drain),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_be       (wb_be),
    .wb_data     (wb_data),
    .lookup_addr (haddr_word),
    .fly_vld     (wb_push),
    .fly_addr    (addr_q),
    .fly_be      (be_q),
    .fly_data    (hwdata),
    .fwd_mask    (wb_fwd_mask),
    .fwd_data    (wb_fwd_data)
  );

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = ST_IDLE;
    addr_d     = addr_q;
    be_d       = be_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (stall) begin
      state_d = ST_WR;
    end else if (acc) begin
      state_d = err ? ST_ERR1 : (hwrite ? ST_WR : ST_RD);
    end
    if (acc && !err) begin
      addr_d = haddr_word;
      be_d   = hlanes;
    end
    if (rd_acc) begin
      fwd_mask_d = wb_fwd_mask;
      fwd_data_d = wb_fwd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // SRAM port: an accepted read owns it, otherwise the buffer drains.
  assign sram_cs    = rd_acc | wb_drain;
  assign sram_we    = wb_drain;
  assign sram_addr  = rd_acc ? haddr_word : wb_addr;
  assign sram_be    = rd_acc ? hlanes : wb_be;
  assign sram_wdata = wb_data;

  always_comb begin
    hrdata = '0;
    if (state_q == ST_RD) begin
      for (int i = 0; i < 4; i++) begin
        hrdata[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : sram_rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_scr1_ahb_sram_bridge.sv
// Bench for scr1_ahb_sram_bridge: a pipelined AHB master replays directed
// transfer lists; a flat memory model (bus-order view of every completed
// write) predicts each read, and a compare process checks the bus outputs
// every cycle. Directed scenarios add literal expectations.
module tb_scr1_ahb_sram_bridge;

  localparam int unsigned AW = 12;
  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10;
  localparam logic [2:0] S_BYTE = 3'd0, S_HALF = 3'd1, S_WORD = 3'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsel, hwrite, hready, hreadyout, hresp;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [31:0]   haddr, hwdata, hrdata;
  logic          sram_cs, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  scr1_ahb_sram_bridge #(.SRAM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .htrans(htrans), .hsize(hsize),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- SRAM model and access counters ----------------
  logic [31:0] mem [0:2**AW-1] = '{default: '0};
  int          wr_cnt = 0, cs_cnt = 0, wr30_cnt = 0;
  logic [3:0]  last_wr_be = '0, last_rd_be = '0;

  always @(posedge clk) begin
    if (sram_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        wr_cnt     <= wr_cnt + 1;
        last_wr_be <= sram_be;
        if (sram_addr == AW'(12)) wr30_cnt <= wr30_cnt + 1;
      end else begin
        sram_rdata <= mem[sram_addr];
        last_rd_be <= sram_be;
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
    if (sz == S_BYTE) return 4'b0001 << a;
    if (sz == S_HALF) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit is_err(input logic [2:0] sz, input logic [31:0] a);
`ifdef SCR1_AHB_SRAM_ERR_EN
    return (sz > S_WORD) || (sz == S_HALF && a[0]) || (sz == S_WORD && a[1:0] != 2'b00)
           || (a[31:AW+2] != '0);
`else
    return (sz == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  logic [31:0] ref_mem [0:2**AW-1] = '{default: '0};

  typedef struct {
    bit          act;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;
  xfer_t xq[$];

  // Data phase currently on the bus, owned by the driver.
  bit          run_active = 0;
  bit          dp_valid = 0, dp_wr = 0, dp_err = 0;
  logic [31:0] dp_addr = '0, dp_wdata = '0;
  logic [2:0]  dp_size = '0;

  int          stall_cnt = 0, err_cycles = 0;
  bit          err_seen = 0;
  logic [31:0] stall_addr = '0, last_rd = '0;

  always @(negedge clk) begin
    if (run_active && rst_n) begin
      if (!dp_valid) begin
        check("idle_ready", hreadyout, 1);
        check("idle_resp", hresp, 0);
      end else if (dp_err) begin
        err_cycles <= err_cycles + 1;
        check("err_resp", hresp, 1);
        check(err_seen ? "err2_ready" : "err1_ready", hreadyout, err_seen ? 1 : 0);
        err_seen <= !err_seen;
      end else if (hreadyout) begin
        check("okay_resp", hresp, 0);
        if (dp_wr) begin
          for (int i = 0; i < 4; i++)
            if (lanes(dp_size, dp_addr[1:0])[i])
              ref_mem[dp_addr[AW+1:2]][8*i +: 8] <= dp_wdata[8*i +: 8];
        end else begin
          check("rd_data", hrdata, ref_mem[dp_addr[AW+1:2]]);
          last_rd <= hrdata;
        end
      end else begin
        stall_cnt  <= stall_cnt + 1;
        stall_addr <= dp_addr;
        check("wait_only_in_write", dp_wr, 1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic q_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    xq.push_back('{act: 1, wr: 1, addr: a, size: sz, wdata: d});
  endtask
  task automatic q_rd(input logic [31:0] a, input logic [2:0] sz);
    xq.push_back('{act: 1, wr: 0, addr: a, size: sz, wdata: 32'h0});
  endtask
  task automatic q_idle();
    xq.push_back('{act: 0, wr: 0, addr: 32'h0, size: S_WORD, wdata: 32'h0});
  endtask

  task automatic drive_idle();
    hsel = 0; htrans = T_IDLE; hwrite = 0; haddr = '0; hsize = S_WORD; hwdata = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 once every queued transfer has
  // finished its data phase.
  task automatic run_seq();
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    dp_valid = 0;
    while ((idx < xq.size() || dp_valid) && cyc < 64) begin
      if (idx < xq.size() && xq[idx].act) begin
        hsel = 1; htrans = T_NONSEQ; hwrite = xq[idx].wr;
        haddr = xq[idx].addr; hsize = xq[idx].size;
      end else begin
        hsel = 0; htrans = T_IDLE; hwrite = 0; haddr = '0; hsize = S_WORD;
      end
      hwdata = (dp_valid && dp_wr) ? dp_wdata : 32'h0;
      @(negedge clk);
      rdy = hreadyout;
      @(posedge clk); #1;
      if (rdy) begin
        if (idx < xq.size()) begin
          dp_valid = xq[idx].act; dp_wr = xq[idx].wr; dp_addr = xq[idx].addr;
          dp_size = xq[idx].size; dp_wdata = xq[idx].wdata;
          dp_err = xq[idx].act && is_err(xq[idx].size, xq[idx].addr);
          idx++;
        end else begin
          dp_valid = 0;
        end
      end
      cyc++;
    end
    check("seq_completes", cyc < 64, 1);
    dp_valid = 0;
    drive_idle();
    xq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  int w0, s0, c0, r0;

  initial begin
    // Reset with a read request already on the bus.
    rst_n = 0;
    hsel = 1; htrans = T_NONSEQ; hwrite = 0; haddr = 32'h10; hsize = S_WORD; hwdata = '0;
    repeat (2) @(negedge clk);
    check("rst_hreadyout", hreadyout, 1);
    check("rst_hresp", hresp, 0);
    check("rst_sram_cs", sram_cs, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_hrdata", hrdata, 32'h0);
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1;
    run_active = 1;
    idle(1);

    // Word write, idle, read back.
    w0 = wr_cnt; s0 = stall_cnt;
    q_wr(32'h10, S_WORD, 32'hDEADBEEF); q_idle(); q_rd(32'h10, S_WORD);
    run_seq(); idle(3);
    check("wr_rd_data", last_rd, 32'hDEADBEEF);
    check("wr_rd_one_write", wr_cnt - w0, 1);
    check("wr_rd_be", last_wr_be, 4'hF);
    check("wr_rd_no_wait", stall_cnt - s0, 0);
    check("wr_rd_mem", mem[4], 32'hDEADBEEF);

    // Byte write forwarded into a back-to-back word read.
    q_wr(32'h10, S_WORD, 32'h11223344);
    run_seq(); idle(3);
    s0 = stall_cnt;
    q_wr(32'h13, S_BYTE, 32'hAA000000); q_rd(32'h10, S_WORD);
    run_seq(); idle(3);
    check("byte_fwd_data", last_rd, 32'hAA223344);
    check("byte_fwd_no_wait", stall_cnt - s0, 0);
    check("byte_fwd_mem", mem[4], 32'hAA223344);

    // Half write plus reads hitting the buffer and missing it.
    q_wr(32'h16, S_HALF, 32'h5A5A0000); q_rd(32'h14, S_WORD); q_rd(32'h10, S_WORD);
    q_wr(32'h11, S_BYTE, 32'h00007700); q_wr(32'h12, S_HALF, 32'h99880000); q_rd(32'h10, S_WORD);
    run_seq(); idle(3);
    check("mixed_last_rd", last_rd, 32'h998877 << 8 | 32'h44);
    check("mixed_mem14", mem[5], 32'h5A5A0000);

    // Two writes then a read: one wait state in the second write's data phase.
    s0 = stall_cnt; w0 = wr_cnt;
    q_wr(32'h20, S_WORD, 32'h01020304); q_wr(32'h24, S_WORD, 32'h05060708); q_rd(32'h28, S_WORD);
    run_seq(); idle(3);
    check("wwr_one_wait", stall_cnt - s0, 1);
    check("wwr_wait_addr", stall_addr, 32'h24);
    check("wwr_mem20", mem[8], 32'h01020304);
    check("wwr_mem24", mem[9], 32'h05060708);
    check("wwr_writes", wr_cnt - w0, 2);
    check("wwr_rd", last_rd, 32'h0);

    // Misaligned word read.
    c0 = cs_cnt; r0 = err_cycles;
    q_rd(32'h02, S_WORD);
    run_seq(); idle(2);
`ifdef SCR1_AHB_SRAM_ERR_EN
    check("mis_no_sram", cs_cnt - c0, 0);
    check("mis_err_cycles", err_cycles - r0, 2);
`else
    check("mis_one_sram", cs_cnt - c0, 1);
    check("mis_be", last_rd_be, 4'hF);
    check("mis_err_cycles", err_cycles - r0, 0);
    check("mis_rd", last_rd, 32'h0);
`endif

    // Reset while the buffer holds a write to 0x30: the write is lost.
    run_active = 0;
    w0 = wr30_cnt;
    hsel = 1; htrans = T_NONSEQ; hwrite = 1; haddr = 32'h30; hsize = S_WORD;
    @(posedge clk); #1;
    hwrite = 0; haddr = 32'h40; hwdata = 32'h30303030;
    @(negedge clk);
    check("w30_ready", hreadyout, 1);
    @(posedge clk); #1;
    drive_idle();
    rst_n = 0;
    #1;
    check("mid_rst_we", sram_we, 0);
    check("mid_rst_cs", sram_cs, 0);
    check("mid_rst_ready", hreadyout, 1);
    check("mid_rst_hrdata", hrdata, 32'h0);
    idle(2);
    rst_n = 1;
    idle(3);
    check("rst_no_w30", wr30_cnt - w0, 0);
    check("rst_mem30", mem[12], 32'h0);
    check("post_rst_ready", hreadyout, 1);
    check("post_rst_resp", hresp, 0);
    run_active = 1;
    q_rd(32'h30, S_WORD);
    run_seq(); idle(2);
    check("post_rst_rd30", last_rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
